// File: rtl/pipeline_stall_controller.sv
// Stall/flush sequencer: merges hazard, branch and SRAM handshake
// into per-stage freeze/flush enables, with watchdog and statistics.
module pipeline_stall_controller #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hazard,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             clr_stats,
  output logic             pc_freeze,
  output logic             if_id_freeze,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             back_freeze,
  output logic             mem_stall,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic {
    RUN,
    MEM_WAIT
  } state_e;

  localparam logic [7:0] TO = 8'(TIMEOUT);

  state_e           state_q, state_d;
  logic [7:0]       wait_cnt_q, wait_cnt_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             stall;

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    timeout_d  = timeout_q;
    stall      = 1'b0;
    unique case (state_q)
      RUN: begin
        if (mem_req && !mem_ready) begin
          stall      = 1'b1;
          state_d    = MEM_WAIT;
          wait_cnt_d = 8'd1;
        end
      end
      MEM_WAIT: begin
        if (mem_ready) begin
          state_d    = RUN;
          wait_cnt_d = 8'd0;
        end else if (wait_cnt_q != TO) begin
          stall      = 1'b1;
          wait_cnt_d = wait_cnt_q + 8'd1;
        end else begin
          // watchdog: release the held access and flag it
          state_d    = RUN;
          wait_cnt_d = 8'd0;
          timeout_d  = 1'b1;
        end
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = 8'd0;
      end
    endcase
  end

  always_comb begin
    mem_stall    = stall;
    back_freeze  = stall;
    pc_freeze    = stall | (hazard & ~branch_taken);
    if_id_freeze = pc_freeze;
    if_id_flush  = branch_taken & ~stall;
    id_ex_flush  = (branch_taken | hazard) & ~stall;
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (pc_freeze && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + 1'b1;
    if (if_id_flush && (flush_cnt_q != '1))
      flush_cnt_d = flush_cnt_q + 1'b1;
    if (clr_stats) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      wait_cnt_q  <= 8'd0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      timeout_q   <= clr_stats ? 1'b0 : timeout_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign mem_timeout = timeout_q;
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;

endmodule
